// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Undefined funct3 encodings count as misaligned so they raise resp_err.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B, SZ_BU: bad = 1'b0;
      SZ_H, SZ_HU: bad = addr_lo[0];
      SZ_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering: store enables/aligned data and load extraction/extension.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Halfwords ignore addr[0] and words ignore addr[1:0]; undefined sizes act as W.
  always_comb begin
    byte_s        = rword[{addr_lo, 3'b000} +: 8];
    half_s        = addr_lo[1] ? rword[31:16] : rword[15:0];
    be            = 4'b0000;
    wdata_aligned = 32'h0000_0000;
    rdata_ext     = 32'h0000_0000;
    case (size)
      SZ_B: begin
        be            = 4'b0001 << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
        rdata_ext     = {{24{byte_s[7]}}, byte_s};
      end
      SZ_BU: begin
        be            = 4'b0001 << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
        rdata_ext     = {24'h00_0000, byte_s};
      end
      SZ_H: begin
        be            = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_aligned = {2{wdata[15:0]}};
        rdata_ext     = {{16{half_s[15]}}, half_s};
      end
      SZ_HU: begin
        be            = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_aligned = {2{wdata[15:0]}};
        rdata_ext     = {16'h0000, half_s};
      end
      default: begin
        be            = 4'b1111;
        wdata_aligned = wdata;
        rdata_ext     = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the M stage of an RV32I pipeline.
// Optional alignment checking is enabled with `define DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int LATENCY        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall_m
);

  localparam int         WORDS    = 1 << (MEM_ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_t               state_r, state_nxt_s;
  logic [3:0]                cnt_r, cnt_nxt_s;
  logic                      cap_we_r;
  logic [2:0]                cap_size_r;
  logic [MEM_ADDR_WIDTH-1:0] cap_addr_r;
  logic [DATA_WIDTH-1:0]     cap_wdata_r;

  logic                      cur_we_s;
  logic [2:0]                cur_size_s;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr_s;
  logic [DATA_WIDTH-1:0]     cur_wdata_s;
  logic                      go_resp_s;
  logic                      err_s;
  logic [3:0]                be_s;
  logic [DATA_WIDTH-1:0]     wdata_al_s;
  logic [DATA_WIDTH-1:0]     rdata_ext_s;
  logic                      unused_addr_s;

  logic [DATA_WIDTH-1:0]     mem [WORDS];

  assign unused_addr_s = ^req_addr[DATA_WIDTH-1:MEM_ADDR_WIDTH];

  // With LATENCY=1 the access happens on the accept edge, so use live inputs in IDLE.
  always_comb begin
    if (state_r == IDLE) begin
      cur_we_s    = req_we;
      cur_size_s  = req_size;
      cur_addr_s  = req_addr[MEM_ADDR_WIDTH-1:0];
      cur_wdata_s = req_wdata;
    end else begin
      cur_we_s    = cap_we_r;
      cur_size_s  = cap_size_r;
      cur_addr_s  = cap_addr_r;
      cur_wdata_s = cap_wdata_r;
    end
  end

  // Alignment check selection.
  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    err_s = is_misaligned(cur_size_s, cur_addr_s[1:0]);
`else
    err_s = 1'b0;
`endif
  end

  dmem_byte_lane u_lane (
    .size          (cur_size_s),
    .addr_lo       (cur_addr_s[1:0]),
    .wdata         (cur_wdata_s),
    .rword         (mem[cur_addr_s[MEM_ADDR_WIDTH-1:2]]),
    .be            (be_s),
    .wdata_aligned (wdata_al_s),
    .rdata_ext     (rdata_ext_s)
  );

  // Next-state and counter logic; WAIT lasts LATENCY-1 cycles.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    go_resp_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (CNT_INIT == 4'd0) begin
            state_nxt_s = RESP;
            go_resp_s   = 1'b1;
          end else begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = CNT_INIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_nxt_s = RESP;
          go_resp_s   = 1'b1;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  assign req_ready = (state_r == IDLE);
  assign stall_m   = ((state_r == IDLE) && req_valid) || (state_r == WAIT);

  // State, counter, request capture and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      cap_we_r    <= 1'b0;
      cap_size_r  <= 3'b000;
      cap_addr_r  <= '0;
      cap_wdata_r <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if ((state_r == IDLE) && req_valid) begin
        cap_we_r    <= req_we;
        cap_size_r  <= req_size;
        cap_addr_r  <= req_addr[MEM_ADDR_WIDTH-1:0];
        cap_wdata_r <= req_wdata;
      end
      resp_valid <= go_resp_s;
      if (go_resp_s) begin
        resp_err   <= err_s;
        resp_rdata <= (cur_we_s || err_s) ? '0 : rdata_ext_s;
      end
    end
  end

  // Array write on the edge entering RESP; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (go_resp_s && cur_we_s && !err_s && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[cur_addr_s[MEM_ADDR_WIDTH-1:2]][8*i +: 8] <= wdata_al_s[8*i +: 8];
        end
      end
    end
  end

endmodule
